// File: rtl/satd_block_engine.sv
// Streaming SATD/SAD cost engine for one N x N block, one pixel row per handshake.
// Rows take a 1-D Hadamard into a transpose buffer; a column pass then accumulates |coef|.
module satd_block_engine #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int OUT_W = WIDTH + 1 + 4 * ((N == 8) ? 3 : 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*N-1:0]   org_row,
    input  logic [WIDTH*N-1:0]   cur_row,
    input  logic                 mode_sad,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     cost,
    output logic                 cost_mode
);
    localparam int LOG2N = (N == 8) ? 3 : 2;
    localparam int DW    = WIDTH + 1;
    localparam int RW    = WIDTH + 1 + LOG2N;
    localparam int CW    = WIDTH + 1 + 2 * LOG2N;

    localparam logic [1:0] S_ROWS  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    if (N != 4 && N != 8) begin : g_bad_n
        $error("satd_block_engine: N must be 4 or 8");
    end

    logic [1:0]             r_state;
    logic [LOG2N-1:0]       r_row_cnt;
    logic [LOG2N-1:0]       r_col_cnt;
    logic [OUT_W-1:0]       r_acc;
    logic                   r_mode;
    logic [OUT_W-1:0]       r_cost;
    logic                   r_cost_mode;
    logic signed [RW-1:0]   r_buf [N][N];

    logic signed [DW-1:0]   w_d  [N];
    logic signed [CW-1:0]   w_rh [LOG2N+1][N];
    logic signed [CW-1:0]   w_ch [LOG2N+1][N];
    logic [OUT_W-1:0]       w_sad_row;
    logic [OUT_W-1:0]       w_satd_col;
    logic                   w_hs;
    logic                   w_mode_eff;

    // Sign-extend one bit before negating so the most negative value stays exact.
    function automatic logic [CW:0] f_abs(input logic signed [CW-1:0] x);
        logic signed [CW:0] t;
        t = {x[CW-1], x};
        return t[CW] ? $unsigned(-t) : $unsigned(t);
    endfunction

    assign in_ready   = (r_state == S_ROWS) && !rst;
    assign out_valid  = (r_state == S_DONE);
    assign cost       = r_cost;
    assign cost_mode  = r_cost_mode;
    assign w_hs       = in_valid && in_ready;
    assign w_mode_eff = (r_row_cnt == '0) ? mode_sad : r_mode;

    // Row differences and butterfly; partner index i^h keeps every stage in range.
    always_comb begin
        w_sad_row = '0;
        for (int k = 0; k < N; k++) begin
            w_d[k]     = {1'b0, cur_row[k*WIDTH +: WIDTH]} - {1'b0, org_row[k*WIDTH +: WIDTH]};
            w_rh[0][k] = CW'(w_d[k]);
            w_sad_row  = w_sad_row + OUT_W'(f_abs(w_rh[0][k]));
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int i = 0; i < N; i++) begin
                if ((i & (1 << s)) == 0)
                    w_rh[s+1][i] = w_rh[s][i] + w_rh[s][i ^ (1 << s)];
                else
                    w_rh[s+1][i] = w_rh[s][i ^ (1 << s)] - w_rh[s][i];
            end
        end
    end

    always_comb begin
        w_satd_col = '0;
        for (int i = 0; i < N; i++)
            w_ch[0][i] = CW'(r_buf[i][r_col_cnt]);
        for (int s = 0; s < LOG2N; s++) begin
            for (int i = 0; i < N; i++) begin
                if ((i & (1 << s)) == 0)
                    w_ch[s+1][i] = w_ch[s][i] + w_ch[s][i ^ (1 << s)];
                else
                    w_ch[s+1][i] = w_ch[s][i ^ (1 << s)] - w_ch[s][i];
            end
        end
        for (int i = 0; i < N; i++)
            w_satd_col = w_satd_col + OUT_W'(f_abs(w_ch[LOG2N][i]));
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int k = 0; k < N; k++)
                r_buf[r_row_cnt][k] <= w_rh[LOG2N][k][RW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ROWS;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_acc       <= '0;
            r_mode      <= 1'b0;
            r_cost      <= '0;
            r_cost_mode <= 1'b0;
        end else begin
            case (r_state)
                S_ROWS: begin
                    if (in_valid) begin
                        if (r_row_cnt == '0)
                            r_mode <= mode_sad;
                        if (w_mode_eff)
                            r_acc <= r_acc + w_sad_row;
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (r_row_cnt == LOG2N'(N - 1)) begin
                            r_state   <= S_FLUSH;
                            r_col_cnt <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!r_mode)
                        r_acc <= r_acc + w_satd_col;
                    r_col_cnt <= r_col_cnt + 1'b1;
                    if (r_col_cnt == LOG2N'(N - 1)) begin
                        r_state     <= S_DONE;
                        r_cost      <= r_mode ? r_acc : r_acc + w_satd_col;
                        r_cost_mode <= r_mode;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_ROWS;
                        r_acc     <= '0;
                        r_row_cnt <= '0;
                    end
                end
                default: r_state <= S_ROWS;
            endcase
        end
    end
endmodule

// File: tb/tb_satd_block_engine.sv
// Randomised self-checking bench for satd_block_engine (N=4 and N=8 instances).
// Expected costs come from a matrix-form Hadamard model of the pixel differences.
module tb_satd_block_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        mode_sad = 1'b0;
    logic        sel8 = 1'b0;
    logic [63:0] org_bus = '0;
    logic [63:0] cur_bus = '0;

    logic        in_ready4, out_valid4, cost_mode4;
    logic [16:0] cost4;
    logic        in_ready8, out_valid8, cost_mode8;
    logic [20:0] cost8;

    logic        w_in_ready, w_out_valid, w_cost_mode;
    int          w_cost;

    logic [7:0]  g_org [8][8];
    logic [7:0]  g_cur [8][8];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    satd_block_engine #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel8), .in_ready(in_ready4),
        .org_row(org_bus[31:0]), .cur_row(cur_bus[31:0]), .mode_sad(mode_sad),
        .out_valid(out_valid4), .out_ready(out_ready & ~sel8),
        .cost(cost4), .cost_mode(cost_mode4)
    );

    satd_block_engine #(.WIDTH(8), .N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel8), .in_ready(in_ready8),
        .org_row(org_bus), .cur_row(cur_bus), .mode_sad(mode_sad),
        .out_valid(out_valid8), .out_ready(out_ready & sel8),
        .cost(cost8), .cost_mode(cost_mode8)
    );

    always_comb begin
        w_in_ready  = sel8 ? in_ready8  : in_ready4;
        w_out_valid = sel8 ? out_valid8 : out_valid4;
        w_cost_mode = sel8 ? cost_mode8 : cost_mode4;
        w_cost      = sel8 ? int'(cost8) : int'(cost4);
    end

    function automatic int hsign(input int a, input int b);
        return ($countones(a & b) % 2) ? -1 : 1;
    endfunction

    // cost = sum |H * D * H^T| (SATD) or sum |D| (SAD), straight from the definition
    function automatic int model_cost(input bit sad, input int n);
        int d [8][8];
        int tot, s;
        tot = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                d[i][j] = int'(g_cur[i][j]) - int'(g_org[i][j]);
        if (sad) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    tot += (d[i][j] < 0) ? -d[i][j] : d[i][j];
        end else begin
            for (int u = 0; u < n; u++)
                for (int v = 0; v < n; v++) begin
                    s = 0;
                    for (int i = 0; i < n; i++)
                        for (int j = 0; j < n; j++)
                            s += hsign(u, i) * d[i][j] * hsign(v, j);
                    tot += (s < 0) ? -s : s;
                end
        end
        return tot;
    endfunction

    task automatic fill(input int org_v, input int cur_v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                g_org[i][j] = org_v[7:0];
                g_cur[i][j] = cur_v[7:0];
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                g_org[i][j] = 8'($urandom);
                g_cur[i][j] = 8'($urandom);
            end
    endtask

    task automatic drive_row(input int r, input int n, input bit mode);
        org_bus = '0;
        cur_bus = '0;
        for (int k = 0; k < n; k++) begin
            org_bus[k*8 +: 8] = g_org[r][k];
            cur_bus[k*8 +: 8] = g_cur[r][k];
        end
        mode_sad = (r == 0) ? mode : 1'($urandom);
        in_valid = 1'b1;
    endtask

    // Entered and left at a negedge. Sends one block, checks latency, hold and release.
    task automatic run_block(input bit mode, input int gap_max, input int hold, input string name);
        int n, exp_cost, edges;
        n = sel8 ? 8 : 4;
        exp_cost = model_cost(mode, n);
        for (int r = 0; r < n; r++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            drive_row(r, n, mode);
            nvec++;
            if (w_in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL %s in_ready row %0d: got %b expected 1", name, r, w_in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        edges = 0;
        while (w_out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        nvec++;
        if (edges != n) begin
            nerr++;
            $display("FAIL %s latency: got %0d edges expected %0d", name, edges, n);
        end
        nvec++;
        if (w_cost !== exp_cost) begin
            nerr++;
            $display("FAIL %s cost: got %0d expected %0d", name, w_cost, exp_cost);
        end
        nvec++;
        if (w_cost_mode !== mode) begin
            nerr++;
            $display("FAIL %s cost_mode: got %b expected %b", name, w_cost_mode, mode);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            mode_sad = 1'($urandom);
            org_bus  = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            nvec++;
            if (w_out_valid !== 1'b1 || w_cost !== exp_cost || w_in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL %s hold %0d: got valid=%b cost=%0d ready=%b expected 1 %0d 0",
                         name, h, w_out_valid, w_cost, w_in_ready, exp_cost);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        nvec++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL %s release: got valid=%b ready=%b expected 0 1", name, w_out_valid, w_in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (in_ready4 !== 1'b0 || in_ready8 !== 1'b0) begin
            nerr++;
            $display("FAIL reset in_ready: got %b %b expected 0 0", in_ready4, in_ready8);
        end
        nvec++;
        if (out_valid4 !== 1'b0 || out_valid8 !== 1'b0) begin
            nerr++;
            $display("FAIL reset out_valid: got %b %b expected 0 0", out_valid4, out_valid8);
        end
        nvec++;
        if (cost4 !== 17'd0 || cost8 !== 21'd0 || cost_mode4 !== 1'b0 || cost_mode8 !== 1'b0) begin
            nerr++;
            $display("FAIL reset cost: got %0d %0d mode %b %b expected 0 0 0 0",
                     cost4, cost8, cost_mode4, cost_mode8);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if (in_ready4 !== 1'b1 || in_ready8 !== 1'b1) begin
            nerr++;
            $display("FAIL reset release in_ready: got %b %b expected 1 1", in_ready4, in_ready8);
        end
    endtask

    task automatic test_zero();
        sel8 = 1'b0;
        fill(8'h80, 8'h80);
        run_block(1'b0, 0, 0, "zero_satd");
    endtask

    task automatic test_plus_one();
        sel8 = 1'b0;
        fill(8'h40, 8'h41);
        run_block(1'b0, 1, 0, "plus1_satd");
        run_block(1'b1, 1, 0, "plus1_sad");
    endtask

    task automatic test_single();
        sel8 = 1'b0;
        fill(8'h10, 8'h10);
        g_cur[0][0] = 8'h11;
        run_block(1'b0, 0, 0, "single_satd");
        run_block(1'b1, 0, 0, "single_sad");
    endtask

    task automatic test_max_neg();
        sel8 = 1'b0;
        fill(8'hFF, 8'h00);
        run_block(1'b0, 0, 0, "maxneg4_satd");
        run_block(1'b1, 0, 0, "maxneg4_sad");
        sel8 = 1'b1;
        run_block(1'b0, 0, 0, "maxneg8_satd");
        sel8 = 1'b0;
    endtask

    task automatic test_backpressure();
        sel8 = 1'b0;
        fill_random();
        run_block(1'b0, 0, 10, "backpressure");
    endtask

    task automatic test_reset_mid();
        sel8 = 1'b0;
        fill_random();
        for (int r = 0; r < 3; r++) begin
            drive_row(r, 4, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_mid state: got valid=%b ready=%b expected 0 1", out_valid4, in_ready4);
        end
        fill(8'h33, 8'h33);
        run_block(1'b1, 0, 0, "reset_mid_sad");
        run_block(1'b0, 0, 0, "reset_mid_satd");
    endtask

    task automatic test_random();
        for (int b = 0; b < 30; b++) begin
            sel8 = (b % 5 == 4);
            fill_random();
            run_block(1'($urandom), 2, $urandom_range(0, 3), "random");
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_plus_one();
        test_single();
        test_max_neg();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
